modn_dir_decoder: RTL and testbench
===================================

MODN_DIR_DECODER -- requirements
Module: modn_dir_decoder

Interface
REQ-001 SHALL have parameter N, default 10, meaning counter modulus; legal range 2..16.
REQ-002 SHALL have parameter W, default 4, meaning sample width; 2**W >= N.
REQ-003 SHALL have port clk  input  1  rising-edge clock, single clock domain.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port cnt_in  input  W  count sample from a mod-N up/down counter.
REQ-006 SHALL have port cnt_vld  input  1  cnt_in qualifier; sample is taken on clk edges with cnt_vld=1.
REQ-007 SHALL have port dir  output  1  decoded direction: 1=up, 0=down.
REQ-008 SHALL have port dir_vld  output  1  dir is trustworthy (locked).
REQ-009 SHALL have port wrap_pulse  output  1  one-cycle pulse on a modulo wrap step.
REQ-010 SHALL have port step_err  output  1  one-cycle pulse on an illegal sample.
REQ-011 SHALL have port err_cnt  output  8  illegal-sample count.

Function
REQ-012 SHALL register every output; flags reflect the sample taken one clk earlier (latency 1).
REQ-013 SHALL classify each valid sample against the stored previous sample prev: UP if cnt_in == (prev==N-1 ? 0 : prev+1); DN if cnt_in == (prev==0 ? N-1 : prev-1); HOLD if cnt_in == prev; else ERR.
REQ-014 SHALL classify any sample with cnt_in >= N as ERR, regardless of prev.
REQ-015 SHALL, when UP and DN both match (N=2), treat the step as the current dir (UP when no direction is held yet).
REQ-016 SHALL implement FSM states IDLE, ACQ, UP, DN, ERR.
REQ-017 IDLE: first valid in-range sample -> store prev, go ACQ; out-of-range -> step_err, stay IDLE.
REQ-018 ACQ: UP -> state UP; DN -> state DN; HOLD -> stay; ERR -> state ERR.
REQ-019 UP/DN: a matching step or HOLD stays; an opposite step switches state (direction reversal is legal); ERR -> state ERR.
REQ-020 ERR: next valid in-range sample -> store prev, go ACQ; out-of-range -> stay ERR.
REQ-021 SHALL drive dir=1 in UP, dir=0 in DN, and hold the last value in other states; dir_vld=1 only in UP or DN.
REQ-022 SHALL pulse wrap_pulse for an UP step N-1->0 or a DN step 0->N-1.
REQ-023 SHALL pulse step_err for every ERR classification, including in IDLE/ERR.
REQ-024 SHALL update prev on every valid in-range sample, including ERR-classified ones.
REQ-025 SHALL ignore cnt_in when cnt_vld=0: no state change, wrap_pulse=0, step_err=0.
REQ-026 SHALL saturate err_cnt at 255.

Reset
REQ-027 SHALL, with reset=0 at any time, asynchronously force state=IDLE, prev=0, dir=0, dir_vld=0, wrap_pulse=0, step_err=0, err_cnt=0.
REQ-028 SHALL resume from IDLE on the first clk edge after reset deasserts, with no stale samples retained.

Configuration
REQ-029 SHALL, with macro MODN_ERRCNT_EN defined, implement the saturating err_cnt register of REQ-026.
REQ-030 SHALL, without MODN_ERRCNT_EN, tie err_cnt to 0 and synthesize no counter; step_err remains.

Structure
REQ-031 SHALL take the FSM state enum, the default N, and the step-class encoding (UP/DN/HOLD/ERR) from shared package modn_pkg.
REQ-032 SHALL place the combinational step classification (REQ-013..015) in sub-module modn_step_cmp, instantiated once.

Verification
REQ-033 N=10, cnt_vld=1, cnt_in 0,1,...,9,0,1 -> dir=1 and dir_vld=1 from the third sample onward; wrap_pulse exactly once, one cycle after the 9->0 sample.
REQ-034 N=10, up to 5 then 4,3,2,1,0,9 -> state UP->DN with no step_err; dir=0 one cycle after the 4 sample; wrap_pulse after the 0->9 sample.
REQ-035 N=10, locked UP at 3, inject 7 -> step_err for one cycle, dir_vld=0, err_cnt=1; then 8,9 -> back in UP, dir_vld=1.
REQ-036 N=10, inject 12 -> step_err with prev unchanged; with MODN_ERRCNT_EN undefined, err_cnt stays 0.
REQ-037 Mid-stream locked DN, assert reset=0 between clk edges -> all outputs clear immediately; after release, first sample yields state ACQ and dir_vld=0.
REQ-038 cnt_vld toggling 1,0,1 with cnt_in 4,(garbage 11),5 -> garbage ignored, no step_err, UP step recognized.

Source files
------------

// File: rtl/modn_pkg.sv
// Shared types for the mod-N direction decoder: FSM states, step classes
// and the default counter modulus.
package modn_pkg;

  localparam int MODN_N_DEFAULT = 10;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ACQ  = 3'd1,
    ST_UP   = 3'd2,
    ST_DN   = 3'd3,
    ST_ERR  = 3'd4
  } modn_state_e;

  typedef enum logic [1:0] {
    STEP_HOLD = 2'd0,
    STEP_UP   = 2'd1,
    STEP_DN   = 2'd2,
    STEP_ERR  = 2'd3
  } modn_step_e;

endpackage

// File: rtl/modn_step_cmp.sv
// Combinational step classifier: compares a new count sample against the
// previously stored sample and reports UP / DN / HOLD / ERR plus whether the
// step crossed the modulo boundary. Ambiguous steps (N=2, UP and DN both
// match) resolve to the currently held direction, or UP if none is held.
module modn_step_cmp
  import modn_pkg::*;
#(
  parameter int N = MODN_N_DEFAULT,
  parameter int W = 4
) (
  input  logic [W-1:0] cnt_in,
  input  logic [W-1:0] prev,
  input  logic         dir,
  input  logic         dir_held,
  output modn_step_e   step,
  output logic         in_range,
  output logic         wrap
);

  localparam logic [W-1:0] LAST  = W'(N - 1);
  localparam logic [W-1:0] ONE   = W'(1);
  localparam logic [W:0]   N_EXT = (W + 1)'(N);

  logic [W-1:0] up_val;
  logic [W-1:0] dn_val;
  logic         up_hit;
  logic         dn_hit;

  // Expected neighbours of prev and the raw match flags.
  always_comb begin
    up_val   = (prev == LAST) ? '0 : prev + ONE;
    dn_val   = (prev == '0) ? LAST : prev - ONE;
    in_range = ({1'b0, cnt_in} < N_EXT);
    up_hit   = (cnt_in == up_val);
    dn_hit   = (cnt_in == dn_val);
  end

  // Classification and wrap detection.
  always_comb begin
    step = STEP_ERR;
    wrap = 1'b0;
    if (!in_range) begin
      step = STEP_ERR;
    end else if (cnt_in == prev) begin
      step = STEP_HOLD;
    end else if (up_hit && dn_hit) begin
      step = (!dir_held || dir) ? STEP_UP : STEP_DN;
    end else if (up_hit) begin
      step = STEP_UP;
    end else if (dn_hit) begin
      step = STEP_DN;
    end else begin
      step = STEP_ERR;
    end
    wrap = ((step == STEP_UP) && (prev == LAST)) ||
           ((step == STEP_DN) && (prev == '0));
  end

endmodule

// File: rtl/modn_dir_decoder.sv
// Mod-N up/down counter direction decoder. Watches a sampled count stream,
// locks onto the counting direction, flags modulo wraps and illegal steps.
// All outputs are registered (one cycle after the sample).
// Optional feature: define MODN_ERRCNT_EN to build the saturating err_cnt
// register; otherwise err_cnt is tied to zero.
//
// Input qualifier: cnt_in is consumed only on a rising clk edge where
// cnt_vld=1; there is no back-pressure, every qualified sample is taken.
module modn_dir_decoder
  import modn_pkg::*;
#(
  parameter int N = MODN_N_DEFAULT,
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] cnt_in,
  input  logic         cnt_vld,
  output logic         dir,
  output logic         dir_vld,
  output logic         wrap_pulse,
  output logic         step_err,
  output logic [7:0]   err_cnt,
  output modn_state_e  state_dbg,
  output logic [W-1:0] prev_dbg
);

  modn_state_e  state_q, state_d;
  logic [W-1:0] prev_q, prev_d;
  logic         dir_d;
  logic         held_q, held_d;
  logic         dir_vld_d;
  logic         wrap_d;
  logic         err_d;

  modn_step_e   step;
  logic         in_range;
  logic         step_wrap;

  modn_step_cmp #(.N(N), .W(W)) u_cmp (
    .cnt_in   (cnt_in),
    .prev     (prev_q),
    .dir      (dir),
    .dir_held (held_q),
    .step     (step),
    .in_range (in_range),
    .wrap     (step_wrap)
  );

  // State, sample history and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      prev_q     <= '0;
      dir        <= 1'b0;
      held_q     <= 1'b0;
      dir_vld    <= 1'b0;
      wrap_pulse <= 1'b0;
      step_err   <= 1'b0;
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      dir        <= dir_d;
      held_q     <= held_d;
      dir_vld    <= dir_vld_d;
      wrap_pulse <= wrap_d;
      step_err   <= err_d;
    end
  end

  // Next-state and next-output decode.
  always_comb begin
    state_d = state_q;
    prev_d  = prev_q;
    wrap_d  = 1'b0;
    err_d   = 1'b0;
    if (cnt_vld) begin
      // Any in-range sample becomes the new reference, even an illegal step.
      if (in_range) prev_d = cnt_in;
      case (state_q)
        ST_IDLE, ST_ERR: begin
          if (in_range) state_d = ST_ACQ;
          else          err_d   = 1'b1;
        end
        ST_ACQ, ST_UP, ST_DN: begin
          case (step)
            STEP_UP: begin
              state_d = ST_UP;
              wrap_d  = step_wrap;
            end
            STEP_DN: begin
              state_d = ST_DN;
              wrap_d  = step_wrap;
            end
            STEP_HOLD: state_d = state_q;
            default: begin
              state_d = ST_ERR;
              err_d   = 1'b1;
            end
          endcase
        end
        default: state_d = ST_IDLE;
      endcase
    end
    // Direction follows the locked state and is held elsewhere.
    dir_d  = dir;
    held_d = held_q;
    if (state_d == ST_UP) begin
      dir_d  = 1'b1;
      held_d = 1'b1;
    end else if (state_d == ST_DN) begin
      dir_d  = 1'b0;
      held_d = 1'b1;
    end
    dir_vld_d = (state_d == ST_UP) || (state_d == ST_DN);
  end

`ifdef MODN_ERRCNT_EN
  logic [7:0] err_cnt_q;

  // Saturating count of illegal samples.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                             err_cnt_q <= '0;
    else if (err_d && (err_cnt_q != 8'hFF)) err_cnt_q <= err_cnt_q + 8'd1;
  end

  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = '0;
`endif

  assign state_dbg = state_q;
  assign prev_dbg  = prev_q;

endmodule

// File: tb/tb_modn_dir_decoder.sv
// Directed bench for modn_dir_decoder (N=10, W=4) with hand-computed
// expected values for every sample.
module tb_modn_dir_decoder;
  import modn_pkg::*;

  localparam int N = 10;
  localparam int W = 4;
`ifdef MODN_ERRCNT_EN
  localparam bit ERRCNT_ON = 1'b1;
`else
  localparam bit ERRCNT_ON = 1'b0;
`endif

  logic         clk;
  logic         reset;
  logic [W-1:0] cnt_in;
  logic         cnt_vld;
  logic         dir;
  logic         dir_vld;
  logic         wrap_pulse;
  logic         step_err;
  logic [7:0]   err_cnt;
  modn_state_e  state_dbg;
  logic [W-1:0] prev_dbg;

  int total = 0;
  int bad   = 0;

  modn_dir_decoder #(.N(N), .W(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .cnt_in     (cnt_in),
    .cnt_vld    (cnt_vld),
    .dir        (dir),
    .dir_vld    (dir_vld),
    .wrap_pulse (wrap_pulse),
    .step_err   (step_err),
    .err_cnt    (err_cnt),
    .state_dbg  (state_dbg),
    .prev_dbg   (prev_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1, "timeout");
  end

  function automatic logic [15:0] ec(input int n);
    return ERRCNT_ON ? 16'(n) : 16'd0;
  endfunction

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // drive one sample at negedge, check registered outputs after the edge
  task automatic step(input string tag, input logic vld, input logic [W-1:0] val,
                      input modn_state_e e_st, input logic e_dir, input logic e_dv,
                      input logic e_wrap, input logic e_err);
    @(negedge clk);
    cnt_vld = vld;
    cnt_in  = val;
    @(posedge clk);
    #1;
    chk({tag, ".state"}, 16'(state_dbg), 16'(e_st));
    chk({tag, ".dir"},   16'(dir),       16'(e_dir));
    chk({tag, ".dvld"},  16'(dir_vld),   16'(e_dv));
    chk({tag, ".wrap"},  16'(wrap_pulse), 16'(e_wrap));
    chk({tag, ".err"},   16'(step_err),  16'(e_err));
  endtask

  initial begin
    reset   = 1'b0;
    cnt_vld = 1'b0;
    cnt_in  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.state", 16'(state_dbg), 16'(ST_IDLE));
    chk("rst.dvld",  16'(dir_vld), 16'd0);
    chk("rst.ecnt",  16'(err_cnt), 16'd0);
    @(negedge clk);
    reset = 1'b1;

    // out-of-range while idle
    step("idle_oor", 1'b1, 4'd13, ST_IDLE, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("idle_oor.ecnt", 16'(err_cnt), ec(1));

    // count up through a wrap
    step("up0", 1'b1, 4'd0, ST_ACQ, 1'b0, 1'b0, 1'b0, 1'b0);
    step("up1", 1'b1, 4'd1, ST_UP,  1'b1, 1'b1, 1'b0, 1'b0);
    for (int v = 2; v <= 9; v++)
      step($sformatf("up%0d", v), 1'b1, 4'(v), ST_UP, 1'b1, 1'b1, 1'b0, 1'b0);
    step("upwrap", 1'b1, 4'd0, ST_UP, 1'b1, 1'b1, 1'b1, 1'b0);
    step("up1b",   1'b1, 4'd1, ST_UP, 1'b1, 1'b1, 1'b0, 1'b0);
    step("up2b",   1'b1, 4'd2, ST_UP, 1'b1, 1'b1, 1'b0, 1'b0);
    step("up3b",   1'b1, 4'd3, ST_UP, 1'b1, 1'b1, 1'b0, 1'b0);

    // illegal jump 3 -> 7, then relock
    step("jump7", 1'b1, 4'd7, ST_ERR, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("jump7.ecnt", 16'(err_cnt), ec(2));
    step("re8", 1'b1, 4'd8, ST_ACQ, 1'b1, 1'b0, 1'b0, 1'b0);
    step("re9", 1'b1, 4'd9, ST_UP,  1'b1, 1'b1, 1'b0, 1'b0);
    chk("re9.ecnt", 16'(err_cnt), ec(2));

    // out-of-range 12 leaves prev at 9
    step("oor12", 1'b1, 4'd12, ST_ERR, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("oor12.prev", 16'(prev_dbg), 16'd9);
    chk("oor12.ecnt", 16'(err_cnt), ec(3));
    step("acq0", 1'b1, 4'd0, ST_ACQ, 1'b1, 1'b0, 1'b0, 1'b0);
    step("lk1",  1'b1, 4'd1, ST_UP,  1'b1, 1'b1, 1'b0, 1'b0);
    for (int v = 2; v <= 5; v++)
      step($sformatf("lk%0d", v), 1'b1, 4'(v), ST_UP, 1'b1, 1'b1, 1'b0, 1'b0);

    // reversal and down wrap
    step("dn4", 1'b1, 4'd4, ST_DN, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int v = 3; v >= 0; v--)
      step($sformatf("dn%0d", v), 1'b1, 4'(v), ST_DN, 1'b0, 1'b1, 1'b0, 1'b0);
    step("dnwrap", 1'b1, 4'd9, ST_DN, 1'b0, 1'b1, 1'b1, 1'b0);

    // asynchronous reset between edges while wrap_pulse is high
    #2;
    reset   = 1'b0;
    cnt_vld = 1'b0;
    #1;
    chk("arst.state", 16'(state_dbg), 16'(ST_IDLE));
    chk("arst.dir",   16'(dir), 16'd0);
    chk("arst.dvld",  16'(dir_vld), 16'd0);
    chk("arst.wrap",  16'(wrap_pulse), 16'd0);
    chk("arst.err",   16'(step_err), 16'd0);
    chk("arst.ecnt",  16'(err_cnt), 16'd0);
    chk("arst.prev",  16'(prev_dbg), 16'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    // first sample after reset, then qualifier gap with garbage
    step("post4",  1'b1, 4'd4,  ST_ACQ, 1'b0, 1'b0, 1'b0, 1'b0);
    step("gap11",  1'b0, 4'd11, ST_ACQ, 1'b0, 1'b0, 1'b0, 1'b0);
    step("post5",  1'b1, 4'd5,  ST_UP,  1'b1, 1'b1, 1'b0, 1'b0);
    for (int v = 6; v <= 9; v++)
      step($sformatf("p%0d", v), 1'b1, 4'(v), ST_UP, 1'b1, 1'b1, 1'b0, 1'b0);
    step("pwrap",  1'b1, 4'd0, ST_UP, 1'b1, 1'b1, 1'b1, 1'b0);
    step("gap3",   1'b0, 4'd3, ST_UP, 1'b1, 1'b1, 1'b0, 1'b0);
    step("hold0",  1'b1, 4'd0, ST_UP, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("hold0.ecnt", 16'(err_cnt), 16'd0);

    // many illegal samples: counter saturates
    @(negedge clk);
    cnt_vld = 1'b1;
    cnt_in  = 4'd15;
    repeat (260) @(posedge clk);
    #1;
    chk("sat.err",   16'(step_err), 16'd1);
    chk("sat.state", 16'(state_dbg), 16'(ST_ERR));
    chk("sat.ecnt",  16'(err_cnt), ERRCNT_ON ? 16'd255 : 16'd0);
    @(negedge clk);
    cnt_vld = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
